// File: rtl/add8_rr_sched.sv
// Round-robin arbiter time-sharing one ripple-carry 8-bit adder among NREQ requesters.
// Latency: one cycle from accept to registered, ID-tagged result; one op per cycle sustained.
// Backpressure: a held result (RSP_VALID && !RSP_READY) drops every REQ_READY until consumed.
module add8_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CW   = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [8*NREQ-1:0] REQ_A,
    input  logic [8*NREQ-1:0] REQ_B,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [8:0]        RSP_O,
    output logic [IDW-1:0]    RSP_ID,
    output logic [CW-1:0]     OP_COUNT,
    output logic              BUSY
);

    logic [IDW-1:0] ptr;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_idx;
    logic [IDW:0]   scan_idx;
    logic           can_accept;
    logic           accept;
    logic [7:0]     op_a;
    logic [7:0]     op_b;
    logic [8:0]     carry;
    logic [8:0]     sum;

    assign can_accept = !RSP_VALID || RSP_READY;
    assign accept     = gnt_vld && can_accept;
    assign BUSY       = RSP_VALID || (|REQ_VALID);

    // Scan from the farthest offset down so the nearest valid requester after ptr wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + (IDW+1)'(k);
            if (scan_idx >= (IDW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IDW+1)'(NREQ);
            end
            if (REQ_VALID[scan_idx[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan_idx[IDW-1:0];
            end
        end
    end

    // Ready is forced low during reset even though the grant logic is combinational.
    always_comb begin
        REQ_READY = '0;
        if (RST_N && accept) begin
            REQ_READY[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                op_a = REQ_A[8*i +: 8];
                op_b = REQ_B[8*i +: 8];
            end
        end
    end

    // Shared exact adder: ripple full-adder chain, no carry-in.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]     = op_a[i] ^ op_b[i] ^ carry[i];
        assign carry[i+1] = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
    assign sum[8] = carry[8];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ptr       <= '0;
            RSP_VALID <= 1'b0;
            RSP_O     <= '0;
            RSP_ID    <= '0;
            OP_COUNT  <= '0;
        end else if (accept) begin
            RSP_VALID <= 1'b1;
            RSP_O     <= sum;
            RSP_ID    <= gnt_idx;
            ptr       <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (OP_COUNT != '1) begin
                OP_COUNT <= OP_COUNT + 1'b1;
            end
        end else if (RSP_READY) begin
            RSP_VALID <= 1'b0;
        end
    end

endmodule
